// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader that writes a program image into IMEM.
// Ports: clk, rst (async high), start, in_valid/in_data/in_ready,
//   imem_we/imem_waddr/imem_wdata, cpu_hold, done, err.
// Image: LEN_LO, LEN_HI (word count N), then 4*N little-endian data bytes.
// Optional macro LOADER_CSUM_EN appends an XOR checksum byte to the image.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
`ifdef LOADER_CSUM_EN
    ,
    S_CSUM   = 3'd5
`endif
  } state_t;

`ifdef LOADER_CSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  // Capacity in words; 17 bits so a 16-bit count compares without wrap.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t state_q, state_d;

  logic [7:0]      len_lo_q;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] word_idx_q;
  logic [ADDR_W:0] word_next;
  logic [1:0]      byte_cnt_q;
  logic [23:0]     asm_q;
  logic [16:0]     n_full;
  logic            acc;
  logic            word_done;
  logic            last_word;
  logic            restart;

`ifdef LOADER_CSUM_EN
  logic [7:0] csum_q;
`endif

  assign acc       = in_valid & in_ready;
  assign n_full    = {1'b0, in_data, len_lo_q};
  assign word_next = word_idx_q + 1'b1;
  assign last_word = (word_next == len_q);
  assign word_done = acc && (state_q == S_DATA)
                     && (byte_cnt_q == 2'd3);
  assign restart   = start && ((state_q == S_DONE)
                     || (state_q == S_ERR));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LEN_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN_LO: begin
        if (acc) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (acc) begin
          if (n_full > CAP)       state_d = S_ERR;
          else if (n_full == '0)  state_d = S_TAIL;
          else                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_done && last_word) state_d = S_TAIL;
      end
`ifdef LOADER_CSUM_EN
      S_CSUM: begin
        if (acc) begin
          if (in_data == csum_q) state_d = S_DONE;
          else                   state_d = S_ERR;
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (start) state_d = S_LEN_LO;
      end
      default: state_d = S_LEN_LO;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA: in_ready = 1'b1;
`ifdef LOADER_CSUM_EN
      S_CSUM:                     in_ready = 1'b1;
`endif
      S_DONE:                     done     = 1'b1;
      S_ERR:                      err      = 1'b1;
      default:                    in_ready = 1'b0;
    endcase
    cpu_hold = ~done;
  end

  // Datapath: length capture, word assembly and IMEM write port.
  // The 4th byte goes straight into imem_wdata, so asm_q is free to
  // take the next word's first byte on the very next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        word_idx_q <= '0;
        byte_cnt_q <= '0;
      end
      if (acc) begin
        case (state_q)
          S_LEN_LO: len_lo_q <= in_data;
          S_LEN_HI: len_q    <= n_full[ADDR_W:0];
          S_DATA: begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: asm_q[7:0]   <= in_data;
              2'd1: asm_q[15:8]  <= in_data;
              2'd2: asm_q[23:16] <= in_data;
              default: begin
                imem_we    <= 1'b1;
                imem_waddr <= word_idx_q[ADDR_W-1:0];
                imem_wdata <= {in_data, asm_q};
                word_idx_q <= word_next;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CSUM_EN
  // Running XOR over every accepted byte, length bytes included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (restart) begin
      csum_q <= '0;
    end else if (acc) begin
      csum_q <= csum_q ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed + randomized bench for imem_loader.
// Uses a queue-based image model; define LOADER_CSUM_EN to match the DUT.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  logic [39:0] wq[$];
  logic [39:0] exp_w[$];
  logic [7:0]  img[$];
  bit          exp_done;
  bit          exp_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(negedge clk)
    if (!rst && imem_we) wq.push_back({imem_waddr, imem_wdata});

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decode the image by its format rules.
  task automatic model();
    int n;
    exp_w.delete();
    n = int'({img[1], img[0]});
    if (n > CAP) begin
      exp_done = 0;
      exp_err  = 1;
      return;
    end
    for (int i = 0; i < n; i++)
      exp_w.push_back({8'(i), img[2+4*i+3], img[2+4*i+2],
                       img[2+4*i+1], img[2+4*i]});
`ifdef LOADER_CSUM_EN
    begin
      logic [7:0] x;
      x = '0;
      for (int j = 0; j < 2 + 4 * n; j++) x ^= img[j];
      exp_done = (img[2+4*n] == x);
      exp_err  = !exp_done;
    end
`else
    exp_done = 1;
    exp_err  = 0;
`endif
  endtask

  task automatic add_csum();
`ifdef LOADER_CSUM_EN
    logic [7:0] x;
    x = '0;
    foreach (img[i]) x ^= img[i];
    img.push_back(x);
`endif
  endtask

  task automatic mk_rand(input int n);
    img.delete();
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    add_csum();
  endtask

  task automatic put_byte(input logic [7:0] b, input bit gaps,
                          input logic st);
    int k;
    k = gaps ? $urandom_range(0, 3) : 0;
    repeat (k) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
    chk("in_ready_active", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic send_img(input bit gaps, input bit noise);
    model();
    wq.delete();
    foreach (img[i])
      put_byte(img[i], gaps, noise &&
               (($urandom_range(0, 1) == 1) || i == img.size() - 1));
  endtask

  task automatic check_result();
    repeat (3) @(negedge clk);
    chk("wr_count", wq.size(), exp_w.size());
    for (int i = 0; i < wq.size() && i < exp_w.size(); i++)
      chk("wr_entry", wq[i], exp_w[i]);
    chk("done", done, exp_done);
    chk("err", err, exp_err);
    chk("cpu_hold", cpu_hold, !exp_done);
    chk("in_ready_end", in_ready, 0);
  endtask

  task automatic run_image(input bit gaps, input bit noise);
    send_img(gaps, noise);
    check_result();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", in_ready, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_waddr", imem_waddr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Two-word image with write/done timing check
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h08, 8'h00, 8'h00, 8'h00};
    add_csum();
    send_img(0, 0);
`ifndef LOADER_CSUM_EN
    chk("t1_we", imem_we, 1);
    chk("t1_waddr", imem_waddr, 1);
    chk("t1_wdata", imem_wdata, 32'h8);
    chk("t1_done", done, 1);
    chk("t1_hold", cpu_hold, 0);
    @(negedge clk);
    chk("t1_we_low", imem_we, 0);
    chk("t1_waddr_hold", imem_waddr, 1);
    chk("t1_wdata_hold", imem_wdata, 32'h8);
`endif
    check_result();

    // Empty image
    do_start();
    img = '{8'h00, 8'h00};
    add_csum();
    run_image(0, 0);

`ifdef LOADER_CSUM_EN
    do_start();
    img = '{8'h00, 8'h00, 8'h01};
    run_image(0, 0);
`endif

    // Oversize count is rejected at the header
    do_start();
    img = '{8'h01, 8'h01};
    run_image(0, 1);
    do_start();

    // N = 3 with random gaps and start noise
    mk_rand(3);
    run_image(1, 1);

    // Reset in the middle of an image
    do_start();
    mk_rand(2);
    for (int i = 0; i < 5; i++) put_byte(img[i], 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_hold", cpu_hold, 1);
    img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    add_csum();
    run_image(0, 0);

`ifdef LOADER_CSUM_EN
    do_start();
    img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_image(0, 0);
    do_start();
    img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
    run_image(1, 0);
`endif

    // Full-capacity image
    do_start();
    mk_rand(CAP);
    run_image(0, 0);

    // Random small images
    for (int r = 0; r < 4; r++) begin
      do_start();
      mk_rand($urandom_range(1, 5));
`ifdef LOADER_CSUM_EN
      if ($urandom_range(0, 1) == 1) img[img.size()-1] ^= 8'h5A;
`endif
      run_image($urandom_range(0, 1) == 1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Receives a byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them sequentially into IMEM starting at word address 0.
- Holds the CPU off (cpu_hold) until a complete, well-formed program image has been loaded.

Parameters:
- ADDR_W, 8, IMEM word-address width; capacity is 2^ADDR_W words (256 by default).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; restarts loading from DONE or ERR; ignored in all other states.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready; a byte is accepted when in_valid & in_ready at the rising edge.
- imem_we  out  1  IMEM write enable, single-cycle pulse per word.
- imem_waddr  out  ADDR_W  IMEM word address.
- imem_wdata  out  32  IMEM write data.
- cpu_hold  out  1  1 = CPU must be held (driven to reset or StallF).
- done  out  1  image loaded successfully.
- err  out  1  image rejected.

Behaviour:
- Image format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, each word little-endian (first byte = bits 7:0). With LOADER_CSUM_EN, one checksum byte follows the data.
- States:
  - LEN_LO: accept a byte -> LEN_HI.
  - LEN_HI: accept a byte ->
    - ERR if N > 2^ADDR_W;
    - DONE if N == 0 (CSUM instead when LOADER_CSUM_EN);
    - DATA otherwise.
  - DATA: byte_cnt (2 bits) counts bytes within a word. On the 4th byte, the word is complete and word_idx increments. On the last word -> DONE (or CSUM).
  - DONE and ERR: sticky; start -> LEN_LO, clearing word_idx, byte_cnt and the checksum.
- in_ready = 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 in DONE and ERR. Combinational from state only, with no dependency on in_valid.
- Write timing: imem_we, imem_waddr and imem_wdata are registered.
  - imem_we pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted.
  - imem_waddr = word index (0, 1, ... N-1).
  - imem_waddr and imem_wdata hold their last value when imem_we = 0.
- Back-to-back bytes: one byte per cycle is sustained; the assembly register must not corrupt a pending write.
- N == 2^ADDR_W: the last write is to address 2^ADDR_W-1. The word index must be wide enough (ADDR_W+1 bits) to compare against N without wrapping.
- Outputs:
  - cpu_hold = ~done.
  - done = 1 only in DONE.
  - err = 1 only in ERR.
- Reset values: state = LEN_LO, in_ready = 1, imem_we = 0, imem_waddr = 0, imem_wdata = 0, cpu_hold = 1, done = 0, err = 0.
- Reset mid-image: all progress is discarded and the next accepted byte is treated as LEN_LO. IMEM contents are not cleared.
- start asserted while in LEN_LO/LEN_HI/DATA/CSUM: ignored.
- start in the same cycle as the transition into DONE: ignored, because start is evaluated only in the DONE/ERR state itself.

Optional Feature:
- Macro: LOADER_CSUM_EN.
- Defined:
  - An 8-bit running XOR covers every accepted byte from LEN_LO onward, including the length bytes.
  - After the last data byte (or after LEN_HI when N == 0), state CSUM accepts one byte.
  - Received byte equal to the running XOR -> DONE, else -> ERR.
  - IMEM writes are still issued during DATA, so a failed image leaves partial contents but keeps cpu_hold = 1.
- Undefined: no CSUM state and no checksum register; the last data byte leads directly to DONE.

Test Plan:
- Reset, then send 02 00 | 13 00 00 00 | 08 00 00 00 -> imem_we pulses twice: (addr 0, 0x00000013), then (addr 1, 0x00000008). done = 1 and cpu_hold = 0 one cycle after the last byte accepted, at the same edge as the final write.
- Send 00 00 -> no imem_we, done = 1. With LOADER_CSUM_EN, also send checksum 00 -> done = 1; send 01 instead -> err = 1.
- Send 01 01 (N = 257 with ADDR_W = 8) -> err = 1, in_ready = 0, no writes. A start pulse returns to LEN_LO with in_ready = 1 and err = 0.
- Send N = 3 with in_valid toggled randomly and bytes issued back-to-back at other times -> exactly 3 writes at addresses 0, 1, 2 with correct words. in_ready never drops before DONE.
- Assert rst after 5 bytes of a 2-word image, then send a full 1-word image 01 00 AA BB CC DD -> single write (addr 0, 0xDDCCBBAA), then done = 1.
- With LOADER_CSUM_EN, send 01 00 11 22 33 44 then checksum 0x45 (XOR of 01, 00, 11, 22, 33, 44) -> done = 1. Same image with checksum 0x46 -> err = 1, cpu_hold = 1, and a write of 0x44332211 at addr 0 still occurs.
